// File: rtl/interp_pkg.sv
// Shared constants, enums and the column-mapping helper for the
// interpolator feeder.
package interp_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_HEIGHT = 16;
    localparam int LEAD_PAD   = 7;
    localparam int TAIL_PAD   = 6;
    localparam int CAP_OFFSET = 13;

    typedef enum logic {
        ROW = 1'b0,
        COL = 1'b1
    } scan_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_e;

    // Map a beat index within a line to its source column. The first and
    // last pixels are replicated to build the lead and tail padding.
    function automatic logic [7:0] src_col(input logic [7:0] k, input int width);
        if (int'(k) < LEAD_PAD) begin
            return 8'd0;
        end else if (int'(k) < width + LEAD_PAD) begin
            return 8'(int'(k) - LEAD_PAD);
        end else begin
            return 8'(width - 1);
        end
    endfunction

endpackage

// File: rtl/frame_store.sv
// Pixel frame store: register array with a synchronous write port and a
// combinational read port.
module frame_store
    import interp_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH * DEF_HEIGHT
) (
    input  logic       clock,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [DEPTH];

    // Write one pixel per cycle when enabled.
    // NOTE: the pixel array has no reset; its contents are only meaningful
    // after the host loads it, and a reset tree over every entry buys nothing.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/interp_feeder.sv
// Scans the frame store row- or column-wise and streams each line with
// edge-replicated padding to a downstream interpolator, flagging the beats
// whose subpixel outputs should be captured and where they belong.
module interp_feeder
    import interp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       mode,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       cap_valid,
    output logic [7:0] cap_pos,
    output logic       busy,
    output logic       done
);

    localparam int         LINE_BEATS = WIDTH + LEAD_PAD + TAIL_PAD;
    localparam logic [7:0] LAST_BEAT  = 8'(LINE_BEATS - 1);
    localparam logic [7:0] LAST_LINE  = 8'(HEIGHT - 1);

    feeder_state_e state_q, state_d;
    scan_mode_e    mode_q, mode_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    k_q, k_d;

    logic [7:0] col;
    logic [7:0] pix_addr;
    logic [7:0] cap_idx;
    logic [7:0] rd_data;
    logic       store_we;

    frame_store #(
        .DEPTH(WIDTH * HEIGHT)
    ) u_frame_store (
        .clock (clock),
        .we    (store_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pix_addr),
        .rdata (rd_data)
    );

    // Read address of the current beat, derived from the line and beat counters.
    always_comb begin
        col      = src_col(k_q, WIDTH);
        pix_addr = (mode_q == ROW) ? 8'(int'(i_q) * WIDTH + int'(col))
                                   : 8'(int'(col) * WIDTH + int'(i_q));
    end

    // Next-state logic, counter advance on accepted beats, and status outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        mode_d   = mode_q;
        i_d      = i_q;
        k_d      = k_q;
        valid    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        store_we = 1'b0;

        case (state_q)
            IDLE: begin
                store_we = wr_en;
                if (start) begin
                    mode_d  = scan_mode_e'(mode);
                    i_d     = 8'd0;
                    k_d     = 8'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                valid = 1'b1;
                busy  = 1'b1;
                if (ready) begin
                    if (k_q == LAST_BEAT) begin
                        k_d = 8'd0;
                        i_d = i_q + 8'd1;
                        if (i_q == LAST_LINE) begin
                            state_d = DONE;
                        end
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat payload and capture tagging, all gated by valid.
    always_comb begin
        cap_idx   = k_q - 8'(CAP_OFFSET);
        data_out  = valid ? rd_data : 8'd0;
        cap_valid = valid && (int'(k_q) >= CAP_OFFSET);
        if (!cap_valid) begin
            cap_pos = 8'd0;
        end else if (mode_q == ROW) begin
            cap_pos = 8'(int'(i_q) * WIDTH + int'(cap_idx));
        end else begin
            cap_pos = 8'(int'(cap_idx) * WIDTH + int'(i_q));
        end
    end

    // State and counter registers with synchronous active-low reset.
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= ROW;
            i_q     <= 8'd0;
            k_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            i_q     <= i_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_interp_feeder.sv
// Self-checking bench for interp_feeder: a queue-based line model built from
// the padding and capture rules, fixed-point table checks, stall, mid-scan
// interference, reset abort and randomized back-pressure scans.
module tb_interp_feeder;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int LB = W + 13;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       mode;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       cap_valid;
    logic [7:0] cap_pos;
    logic       busy;
    logic       done;

    always #5 clock = ~clock;

    interp_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .mode      (mode),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .cap_valid (cap_valid),
        .cap_pos   (cap_pos),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [7:0] d;
        logic       cv;
        logic [7:0] cp;
    } beat_t;

    typedef struct {
        int         m;
        int         l;
        int         b;
        logic [7:0] d;
        logic       cv;
        logic [7:0] cp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [W*H];
    beat_t      exp_q [$];
    logic [7:0] obs_d  [2][H][LB];
    logic       obs_cv [2][H][LB];
    logic [7:0] obs_cp [2][H][LB];
    vec_t       tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Fill the frame: ramp (frame[a] = a) or random pixels.
    task automatic load_frame(input bit rnd);
        for (int a = 0; a < W*H; a++) begin
            @(negedge clock);
            wr_en   = 1'b1;
            wr_addr = 8'(a);
            wr_data = rnd ? 8'($urandom) : 8'(a);
            model[a] = wr_data;
        end
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Expected beat stream for a whole scan: per line, 7 copies of the first
    // pixel, the line itself, 6 copies of the last; captures start on beat 13
    // and walk the line's frame indices in order.
    task automatic build_expected(input int m);
        logic [7:0] pix [W];
        logic [7:0] pos [W];
        logic [7:0] dq [$];
        logic       cq [$];
        logic [7:0] pq [$];
        exp_q.delete();
        for (int l = 0; l < H; l++) begin
            dq.delete();
            cq.delete();
            pq.delete();
            for (int j = 0; j < W; j++) begin
                pos[j] = 8'((m != 0) ? j * W + l : l * W + j);
                pix[j] = model[pos[j]];
            end
            repeat (7) dq.push_back(pix[0]);
            for (int j = 0; j < W; j++) dq.push_back(pix[j]);
            repeat (6) dq.push_back(pix[W-1]);
            repeat (13) begin
                cq.push_back(1'b0);
                pq.push_back(8'd0);
            end
            for (int j = 0; j < W; j++) begin
                cq.push_back(1'b1);
                pq.push_back(pos[j]);
            end
            for (int n = 0; n < dq.size(); n++) exp_q.push_back('{dq[n], cq[n], pq[n]});
        end
    endtask

    // Run one scan, comparing every live beat with the head of the expected
    // stream (head is popped only on acceptance, so stalls check the hold).
    task automatic run_scan(input int m, input bit rnd, input int stall_l, input int stall_b,
                            input int stall_n, input bit mid, input int abort_l, input int abort_b,
                            output int run_cyc, output int done_cnt);
        int    l;
        int    b;
        int    guard;
        int    stall_left;
        int    abort_done;
        bit    pulsed;
        beat_t e;
        build_expected(m);
        l = 0;
        b = 0;
        run_cyc = 0;
        done_cnt = 0;
        stall_left = stall_n;
        pulsed = 1'b0;
        @(negedge clock);
        start = 1'b1;
        mode  = m[0];
        ready = 1'b1;
        for (guard = 0; guard < 3000; guard++) begin
            @(negedge clock);
            start = 1'b0;
            wr_en = 1'b0;
            mode  = m[0];
            if (!busy) break;
            ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd && $urandom_range(0, 7) == 0) begin
                wr_en   = 1'b1;
                wr_addr = 8'($urandom);
                wr_data = 8'($urandom);
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_beat", exp_q.size(), 0);
            end
            if (valid) begin
                run_cyc++;
                if (l == abort_l && b == abort_b) begin
                    reset_n = 1'b0;
                    @(negedge clock);
                    check("abort_valid", valid, 0);
                    check("abort_busy", busy, 0);
                    check("abort_done", done, 0);
                    reset_n = 1'b1;
                    abort_done = 0;
                    repeat (6) begin
                        @(negedge clock);
                        if (done) abort_done++;
                    end
                    check("abort_no_done_pulse", abort_done, 0);
                    return;
                end
                if (l == stall_l && b == stall_b && stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                end
                if (mid && !pulsed && l == 8 && b == 3) begin
                    start   = 1'b1;
                    mode    = ~m[0];
                    wr_en   = 1'b1;
                    wr_addr = 8'd0;
                    wr_data = 8'd99;
                    pulsed  = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q[0];
                    check($sformatf("beat_m%0d_l%0d_b%0d", m, l, b),
                          {cap_valid, cap_pos, data_out}, {e.cv, e.cp, e.d});
                    if (ready) begin
                        obs_d[m][l][b]  = data_out;
                        obs_cv[m][l][b] = cap_valid;
                        obs_cp[m][l][b] = cap_pos;
                        void'(exp_q.pop_front());
                        b++;
                        if (b == LB) begin
                            b = 0;
                            l++;
                        end
                    end
                end
            end
        end
        if (guard >= 3000) check("scan_timeout", 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int dc;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 8'd0;
        wr_data = 8'd0;
        start   = 1'b0;
        mode    = 1'b0;
        ready   = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_valid", valid, 0);
        check("reset_cap_valid", cap_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_data_out", data_out, 0);
        reset_n = 1'b1;

        // Reference points on the ramp frame (frame[a] = a).
        for (int b = 0; b <= 7; b++) tbl.push_back('{0, 3, b, 8'd48, 1'b0, 8'd0});
        tbl.push_back('{0, 3, 12, 8'd53, 1'b0, 8'd0});
        tbl.push_back('{0, 3, 13, 8'd54, 1'b1, 8'd48});
        for (int b = 22; b <= 28; b++) tbl.push_back('{0, 3, b, 8'd63, 1'b1, 8'(48 + b - 13)});
        for (int b = 7; b <= 22; b++)
            tbl.push_back('{1, 2, b, 8'(2 + 16 * (b - 7)), (b >= 13), (b >= 13) ? 8'((b - 13) * 16 + 2) : 8'd0});
        for (int b = 23; b <= 28; b++) tbl.push_back('{1, 2, b, 8'd242, 1'b1, 8'((b - 13) * 16 + 2)});

        load_frame(1'b0);

        // Row scan with a start/write pulse mid-scan.
        run_scan(0, 1'b0, -1, -1, 0, 1'b1, -1, -1, rc, dc);
        check("row_run_cycles", rc, 464);
        check("row_done_count", dc, 1);

        // Column scan; frame[0] must still hold 0 despite the mid-scan write.
        run_scan(1, 1'b0, -1, -1, 0, 1'b0, -1, -1, rc, dc);
        check("col_run_cycles", rc, 464);
        check("col_done_count", dc, 1);
        check("frame0_kept", obs_d[1][0][0], 0);

        for (int n = 0; n < tbl.size(); n++) begin
            check($sformatf("tbl_m%0d_l%0d_b%0d", tbl[n].m, tbl[n].l, tbl[n].b),
                  {obs_cv[tbl[n].m][tbl[n].l][tbl[n].b], obs_cp[tbl[n].m][tbl[n].l][tbl[n].b],
                   obs_d[tbl[n].m][tbl[n].l][tbl[n].b]},
                  {tbl[n].cv, tbl[n].cp, tbl[n].d});
        end

        // Three-cycle back-pressure at line 0 beat 10.
        run_scan(0, 1'b0, 0, 10, 3, 1'b0, -1, -1, rc, dc);
        check("stall_run_cycles", rc, 467);
        check("stall_done_count", dc, 1);

        // Reset abort at line 5 beat 9, then a fresh scan from line 0 beat 0.
        run_scan(0, 1'b0, -1, -1, 0, 1'b0, 5, 9, rc, dc);
        check("abort_scan_done_count", dc, 0);
        run_scan(0, 1'b0, -1, -1, 0, 1'b0, -1, -1, rc, dc);
        check("replay_run_cycles", rc, 464);
        check("replay_done_count", dc, 1);

        // Random frames, random mode, random back-pressure and dropped writes.
        repeat (3) begin
            load_frame(1'b1);
            run_scan(int'($urandom_range(0, 1)), 1'b1, -1, -1, 0, 1'b0, -1, -1, rc, dc);
            check("rand_done_count", dc, 1);
            check("rand_run_at_least_464", (rc >= 464), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interp_feeder.md
INTERP_FEEDER -- requirements
Module: interp_feeder

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set pixels per row.
REQ-002 Parameter HEIGHT, default 16, SHALL set rows per frame.
REQ-003 Port clock, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the synchronous, active-low reset.
REQ-005 Port wr_en, input, 1, SHALL request a frame-store write this cycle.
REQ-006 Port wr_addr, input, 8, SHALL give the write address, row*WIDTH+col.
REQ-007 Port wr_data, input, 8, SHALL give the pixel to write.
REQ-008 Port start, input, 1, SHALL request a full-frame scan (single-cycle pulse).
REQ-009 Port mode, input, 1, SHALL select the scan: 0 = row scan, 1 = column scan; sampled on accepted start.
REQ-010 Port ready, input, 1, SHALL indicate the downstream interpolator accepts a beat this cycle.
REQ-011 Port data_out, output, 8, SHALL carry the current padded pixel beat.
REQ-012 Port valid, output, 1, SHALL mark data_out as a live beat.
REQ-013 Port cap_valid, output, 1, SHALL mark beats on which the downstream subpixel outputs are to be captured.
REQ-014 Port cap_pos, output, 8, SHALL give the frame index the captured subpixel belongs to.
REQ-015 Port busy, output, 1, SHALL be high while a scan is in progress.
REQ-016 Port done, output, 1, SHALL pulse high for one cycle when a scan completes.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE on acceptance of the last beat, and DONE->IDLE unconditionally.
REQ-018 In IDLE, start SHALL latch mode, clear line counter i and beat counter k, and enter RUN the next cycle.
REQ-019 Each line SHALL be WIDTH+13 beats long (k = 0..WIDTH+12), and i SHALL run 0..HEIGHT-1.
REQ-020 A beat SHALL be accepted when valid && ready; k SHALL advance only on acceptance, and on k = WIDTH+12 k SHALL wrap to 0 and i SHALL increment.
REQ-021 Source column c SHALL be 0 for k < 7, k-7 for 7 <= k <= WIDTH+6, and WIDTH-1 for k > WIDTH+6 (edge replication).
REQ-022 data_out SHALL equal frame[i*WIDTH+c] in row mode and frame[c*WIDTH+i] in column mode, combinationally from the current i and k.
REQ-023 valid SHALL be high in RUN only; data_out SHALL be 0 outside RUN.
REQ-024 cap_valid SHALL equal valid && (k >= 13); cap_pos SHALL be i*WIDTH+(k-13) in row mode and (k-13)*WIDTH+i in column mode, and 0 when cap_valid is low.
REQ-025 While ready is low, k, i, data_out, cap_valid and cap_pos SHALL hold unchanged.
REQ-026 busy SHALL be high in RUN and DONE; done SHALL be high only in DONE.
REQ-027 A start pulse outside IDLE SHALL be ignored.
REQ-028 A write with wr_en high SHALL update frame[wr_addr] at the clock edge in IDLE only; writes while busy SHALL be dropped.
REQ-029 With ready held high, a scan SHALL take exactly HEIGHT*(WIDTH+13) RUN cycles (464 at the defaults), followed by one DONE cycle.

Reset
REQ-030 With reset_n low at a clock edge, the FSM SHALL enter IDLE, i, k and the latched mode SHALL clear to 0, and valid, cap_valid, busy and done SHALL read 0 in the following cycle.
REQ-031 Reset SHALL abort a scan at any beat without emitting done; frame-store contents need not be cleared.

Structure
REQ-032 Package interp_pkg SHALL hold WIDTH/HEIGHT defaults, LEAD_PAD = 7, TAIL_PAD = 6, CAP_OFFSET = 13, the scan_mode_e enum (ROW, COL) and the feeder state enum.
REQ-033 The frame store SHALL be the sub-module frame_store: a WIDTH*HEIGHT x 8 register array with synchronous write and combinational read.

Verification
REQ-034 The bench SHALL load frame[a] = a, run a row scan with ready = 1, and check for line 3: beats 0-7 = 48, beat 22 = 63, beats 23-28 = 63, beat 13 carries cap_pos = 48.
REQ-035 The bench SHALL run a column scan on the same frame and check for line 2: beats 7..22 = 2, 18, ..., 242, beats 23-28 = 242, beat 28 carries cap_pos = 242.
REQ-036 The bench SHALL drop ready for 3 cycles at row-scan line 0 beat 10 and check that data_out stays 3, cap_valid stays 0, and the total scan runs 467 RUN cycles.
REQ-037 The bench SHALL pulse start and wr_en (addr 0, data 99) mid-scan and check that the scan is unaffected, frame[0] stays 0, and done pulses exactly once after beat 463.
REQ-038 The bench SHALL assert reset_n low at line 5 beat 9 and check that valid, busy and done are 0 the next cycle, no done pulse appears, and a fresh start replays line 0 from beat 0.
